// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with bounded grant hold and a one-cycle gap between owners
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - asynchronous active-low reset
//   req     - per-requester request bits
//   gnt     - registered one-hot grant, zero when nobody owns the resource
//   gnt_id  - index of the current or most recent owner
//   gnt_vld - high while a grant is active
//   timeout - one-cycle pulse in the gap that follows a hold-limit revocation
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  state_t state, state_nx;
  logic [2:0] ptr, ptr_nx, id_nx, win;
  logic [7:0] cnt, cnt_nx;
  logic vld_nx, to_nx;
  // descending scan so the closest requester at or after ptr is the last one written
  always_comb begin
    win = ptr;
    for (int k = 7; k >= 0; k--)
      if (req[ptr + 3'(k)]) win = ptr + 3'(k);
  end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    id_nx = gnt_id;
    cnt_nx = cnt;
    vld_nx = 1'b0;
    to_nx = 1'b0;
    if (state == GRANT) begin
      if (!req[gnt_id] || cnt == HOLD_MAX) begin
        state_nx = GAP;
        ptr_nx = gnt_id + 3'd1;
        to_nx = req[gnt_id];
      end else begin
        cnt_nx = cnt + 8'd1;
        vld_nx = 1'b1;
      end
    end else if (|req) begin
      state_nx = GRANT;
      id_nx = win;
      cnt_nx = 8'd0;
      vld_nx = 1'b1;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 3'd0;
      cnt <= 8'd0;
      gnt <= 8'h00;
      gnt_id <= 3'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      gnt <= vld_nx ? 8'b1 << id_nx : 8'h00;
      gnt_id <= id_nx;
      gnt_vld <= vld_nx;
      timeout <= to_nx;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed vector table plus rotation, expiry and async-reset sequences
module tb_rr_arbiter_8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic gnt_vld, timeout;
  int checks = 0, failures = 0;
  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] id;
    logic v;
    logic t;
  } vec_t;
  vec_t tbl[26];
  always #5 clk = ~clk;
  rr_arbiter_8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );
  task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] id, input logic v, input logic t);
    checks++;
    if (gnt !== g || gnt_id !== id || gnt_vld !== v || timeout !== t) begin
      failures++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
               nm, gnt, gnt_id, gnt_vld, timeout, g, id, v, t);
    end
  endtask
  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    req = 8'h00;
    rst_n = 1'b0;
    #1 chk("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    tbl = '{
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0},
      '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0},
      '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0},
      '{8'h00, 8'h00, 3'd1, 1'b0, 1'b0},
      '{8'h41, 8'h40, 3'd6, 1'b1, 1'b0},
      '{8'h41, 8'h40, 3'd6, 1'b1, 1'b0},
      '{8'h81, 8'h00, 3'd6, 1'b0, 1'b0},
      '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0},
      '{8'h01, 8'h00, 3'd7, 1'b0, 1'b0},
      '{8'h81, 8'h01, 3'd0, 1'b1, 1'b0},
      '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0},
      '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0},
      '{8'hFF, 8'h08, 3'd3, 1'b1, 1'b0},
      '{8'hFF, 8'h08, 3'd3, 1'b1, 1'b0},
      '{8'hF7, 8'h00, 3'd3, 1'b0, 1'b0},
      '{8'hFF, 8'h10, 3'd4, 1'b1, 1'b0},
      '{8'h00, 8'h00, 3'd4, 1'b0, 1'b0},
      '{8'h00, 8'h00, 3'd4, 1'b0, 1'b0}
    };
    #1 rst_n = 1'b0;
    #1 chk("reset_initial", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].r);
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].v, tbl[i].t);
    end
    do_reset();
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 16; c++) begin
        step(8'hFF);
        chk($sformatf("rotate_o%0d_c%0d", o, c), 8'b1 << (o % 8), 3'(o % 8), 1'b1, 1'b0);
      end
      step(8'hFF);
      chk($sformatf("expire_o%0d", o), 8'h00, 3'(o % 8), 1'b0, 1'b1);
    end
    do_reset();
    step(8'h20);
    chk("pre_rst_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'hFF;
    @(posedge clk);
    #1 chk("rst_held_edge", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    req = 8'h24;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles per owner; legal range 2..256.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-requester request; req[i] high = requester i wants the shared resource.
REQ-005 gnt  output  8  one-hot grant; bit i high = requester i owns the resource; all-zero when no owner.
REQ-006 gnt_id  output  3  binary index of current or last owner.
REQ-007 gnt_vld  output  1  high when exactly one gnt bit is high.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT, GAP. All outputs SHALL be registered.
REQ-010 gnt SHALL always equal the 3-to-8 one-hot decode of gnt_id (bit gnt_id set) when gnt_vld=1, and 8'h00 when gnt_vld=0.
REQ-011 Round-robin pointer ptr (3 bits) SHALL select the search start; winner = first i with req[i]=1, searching ptr, ptr+1, ..., wrapping 7->0.
REQ-012 IDLE: if req!=0 at an edge, the block SHALL load gnt_id=winner, set gnt_vld=1, clear hold counter, and enter GRANT; latency from req sampled high to gnt high = 1 cycle.
REQ-013 IDLE with req==0 SHALL remain in IDLE with gnt=0, gnt_vld=0, gnt_id unchanged.
REQ-014 GRANT: hold counter (8 bits) SHALL increment each cycle the owner keeps req[gnt_id]=1 and counter < MAX_HOLD-1.
REQ-015 GRANT release: when req[gnt_id]=0 is sampled, the block SHALL enter GAP, deassert gnt/gnt_vld next cycle, and set ptr=gnt_id+1 mod 8.
REQ-016 GRANT expiry: when req[gnt_id]=1 and counter = MAX_HOLD-1, the block SHALL enter GAP, deassert gnt, set ptr=gnt_id+1 mod 8, and pulse timeout for exactly that GAP cycle.
REQ-017 Grant duration SHALL therefore be at most MAX_HOLD cycles; requests of other requesters SHALL NOT preempt an active grant.
REQ-018 GAP SHALL last exactly one cycle with gnt=0; at its end the block SHALL arbitrate as in IDLE (enter GRANT if req!=0, else IDLE).
REQ-019 Minimum back-to-back spacing: release sampled at edge R -> gnt low from R to R+1 -> next grant high at edge R+1 (one dead cycle).
REQ-020 A requester that timed out and still requests SHALL be considered again only after all other pending requesters per ptr order.
REQ-021 Pointer wrap: owner 7 released -> ptr=0.
REQ-022 Changes on req bits other than req[gnt_id] during GRANT SHALL have no effect until the next arbitration.
REQ-023 gnt_id SHALL retain its last value through GAP and IDLE.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, gnt=8'h00, gnt_vld=0, gnt_id=0, timeout=0, ptr=0, counter=0, regardless of clk.
REQ-025 Reset asserted mid-grant SHALL drop gnt asynchronously; after rst_n rises, the first arbitration SHALL start from ptr=0.

Verification
REQ-026 Reset then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_vld=0, gnt_id=0 throughout.
REQ-027 req=8'h01 at edge 1, held 3 cycles then dropped -> gnt=8'h01 from edge 1 for 3 cycles, then 1 cycle gnt=0, timeout=0, ptr=1.
REQ-028 req=8'hFF held constantly, MAX_HOLD=16 -> grants rotate 0,1,...,7,0 each 16 cycles long separated by one dead cycle; timeout pulses once per grant; gnt always one-hot.
REQ-029 ptr=7 (owner 6 released), req=8'h81 -> gnt=8'h80 (gnt_id=7); after release, req=8'h81 -> gnt=8'h01 (wrap).
REQ-030 Owner 3 active with req=8'h08, raise req=8'hFF -> gnt stays 8'h08 until req[3] drops or expiry; next grant gnt=8'h10.
REQ-031 rst_n pulsed low mid-grant with gnt=8'h20 -> gnt=8'h00 immediately; after release with req=8'h24, first grant gnt=8'h04.
